serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 118 +++++++++++
 tb/tb_serial_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx -- UART-style serial transmitter (8N1, optional even parity)
//
// Sends one byte per accepted transmit request as a frame of
//   start(0), tx_data[0] .. tx_data[7], [parity], stop(1)
// with every bit held on the line for BAUD_DIV clocks.
//
// Parameters
//   BAUD_DIV  clocks per serial bit period (2..65535), default 16
//
// Ports
//   clk      in   single clock, all state updates on its rising edge
//   rst      in   asynchronous active-high reset
//   trmt     in   transmit request, accepted only while idle
//   tx_data  in   byte to send, captured in the cycle trmt is accepted
//   tx       out  serial line, idle high, driven straight from a flop
//   tx_done  out  frame-complete flag, held until the next accepted trmt
//
// Build option
//   SERIAL_TX_PARITY_EN  when defined, an even-parity bit (XOR of tx_data)
//                        is sent between tx_data[7] and the stop bit,
//                        making the frame 11 bits long.
// -----------------------------------------------------------------------------
module serial_tx #(
   parameter int BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_done
);

`ifdef SERIAL_TX_PARITY_EN
   localparam int FRAME_LEN = 11;
`else
   localparam int FRAME_LEN = 10;
`endif

   localparam int BAUD_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [3:0]        BIT_LAST  = 4'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE = 1'b0,
      XMIT = 1'b1
   } state_t;

   state_t                state_reg;
   logic [FRAME_LEN-1:0]  shift_reg;
   logic [BAUD_W-1:0]     baud_cnt_reg;
   logic [3:0]            bit_cnt_reg;
   logic                  tx_reg;
   logic                  tx_done_reg;

   // Complete frame image, start bit in bit 0 so it is shifted out first.
   logic [FRAME_LEN-1:0]  frame_load;

`ifdef SERIAL_TX_PARITY_EN
   assign frame_load = {1'b1, ^tx_data, tx_data, 1'b0};
`else
   assign frame_load = {1'b1, tx_data, 1'b0};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         shift_reg    <= '1;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         tx_reg       <= 1'b1;
         tx_done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (trmt) begin
                  // The start bit goes onto the line on the accepting edge.
                  shift_reg    <= frame_load;
                  tx_reg       <= 1'b0;
                  tx_done_reg  <= 1'b0;
                  baud_cnt_reg <= '0;
                  bit_cnt_reg  <= '0;
                  state_reg    <= XMIT;
               end
            end

            XMIT: begin
               if (baud_cnt_reg == BAUD_LAST) begin
                  baud_cnt_reg <= '0;
                  if (bit_cnt_reg == BIT_LAST) begin
                     // Stop bit has had its full period; the line is
                     // already high, so just flag completion.
                     bit_cnt_reg <= '0;
                     tx_reg      <= 1'b1;
                     tx_done_reg <= 1'b1;
                     state_reg   <= IDLE;
                  end else begin
                     // Present the next bit from the pre-shift image so tx
                     // changes on the same edge the register shifts.
                     bit_cnt_reg <= bit_cnt_reg + 4'd1;
                     shift_reg   <= {1'b1, shift_reg[FRAME_LEN-1:1]};
                     tx_reg      <= shift_reg[1];
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + 1'b1;
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign tx      = tx_reg;
   assign tx_done = tx_done_reg;

endmodule

// File: tb/tb_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_tx -- self-checking bench for serial_tx with BAUD_DIV = 4.
// Each clock of expected line activity is queued as {tx, tx_done} when a
// frame is requested and popped/compared on the following falling edges.
// -----------------------------------------------------------------------------
module tb_serial_tx;

   localparam int BAUD = 4;
`ifdef SERIAL_TX_PARITY_EN
   localparam int FBITS = 11;
`else
   localparam int FBITS = 10;
`endif
   localparam int FCLKS = FBITS * BAUD;

   logic       clk;
   logic       rst;
   logic       trmt;
   logic [7:0] tx_data;
   logic       tx;
   logic       tx_done;

   int errors = 0;
   int checks = 0;

   logic [1:0] exp_q[$];   // {tx, tx_done} expected per clock

   serial_tx #(.BAUD_DIV(BAUD)) dut (
      .clk     (clk),
      .rst     (rst),
      .trmt    (trmt),
      .tx_data (tx_data),
      .tx      (tx),
      .tx_done (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference frame: start, LSB-first data, optional even parity, stop.
   function automatic void push_frame(input logic [7:0] d);
      logic [FBITS-1:0] bits;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
`ifdef SERIAL_TX_PARITY_EN
      bits[9]  = ^d;
      bits[10] = 1'b1;
`else
      bits[9]  = 1'b1;
`endif
      for (int b = 0; b < FBITS; b++)
         for (int c = 0; c < BAUD; c++)
            exp_q.push_back({bits[b], 1'b0});
   endfunction

   // Present a request so that it is sampled on the next rising edge.
   task automatic request(input logic [7:0] d);
      @(negedge clk);
      trmt    = 1'b1;
      tx_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [1:0] exp;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx, tx_done} !== 2'b10) begin
         errors++;
         $display("FAIL reset_hold tx/done got %b want 10", {tx, tx_done});
      end
      rst = 1'b0;
      for (int k = 0; k < 20; k++) exp_q.push_back(2'b10);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         checks++;
         if ({tx, tx_done} !== exp) begin
            errors++;
            $display("FAIL reset_idle tx/done got %b want %b", {tx, tx_done}, exp);
         end
      end
      $display("test_reset: idle line checked for 20 clocks");
   endtask

   task automatic test_frame(input logic [7:0] d);
      logic [1:0] exp;
      int k;
      push_frame(d);
      exp_q.push_back(2'b11);
      for (int i = 0; i < 4; i++) exp_q.push_back(2'b11);
      request(d);
      trmt = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         checks++;
         if ({tx, tx_done} !== exp) begin
            errors++;
            $display("FAIL frame_%02h clk=%0d tx/done got %b want %b", d, k, {tx, tx_done}, exp);
         end
         k++;
      end
      $display("test_frame: data=%02h sent", d);
   endtask

   task automatic test_ignore;
      logic [1:0] exp;
      int k;
      push_frame(8'hA5);
      exp_q.push_back(2'b11);
      for (int i = 0; i < 2 * FCLKS; i++) exp_q.push_back(2'b11);
      request(8'hA5);
      trmt = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         checks++;
         if ({tx, tx_done} !== exp) begin
            errors++;
            $display("FAIL ignore clk=%0d tx/done got %b want %b", k, {tx, tx_done}, exp);
         end
         if (k == 12) begin
            trmt    = 1'b1;
            tx_data = 8'h00;
         end else if (k == 13) begin
            trmt = 1'b0;
         end
         k++;
      end
      $display("test_ignore: mid-frame request discarded");
   endtask

   task automatic test_reset_mid;
      logic [1:0] exp;
      int k;
      push_frame(8'h00);
      request(8'h00);
      trmt = 1'b0;
      for (k = 0; k <= 17; k++) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         checks++;
         if ({tx, tx_done} !== exp) begin
            errors++;
            $display("FAIL reset_mid_pre clk=%0d tx/done got %b want %b", k, {tx, tx_done}, exp);
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({tx, tx_done} !== 2'b10) begin
         errors++;
         $display("FAIL reset_mid_async tx/done got %b want 10", {tx, tx_done});
      end
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) exp_q.push_back(2'b10);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         checks++;
         if ({tx, tx_done} !== exp) begin
            errors++;
            $display("FAIL reset_mid_after tx/done got %b want %b", {tx, tx_done}, exp);
         end
      end
      $display("test_reset_mid: frame aborted, line idle");
   endtask

   task automatic test_back_to_back;
      logic [1:0] exp;
      int k;
      push_frame(8'h3C);
      exp_q.push_back(2'b11);      // one clock of IDLE with done set
      push_frame(8'h3C);           // second frame, done low throughout
      exp_q.push_back(2'b11);
      for (int i = 0; i < 4; i++) exp_q.push_back(2'b11);
      request(8'h3C);              // trmt left high
      k = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         exp = exp_q.pop_front();
         checks++;
         if ({tx, tx_done} !== exp) begin
            errors++;
            $display("FAIL back_to_back clk=%0d tx/done got %b want %b", k, {tx, tx_done}, exp);
         end
         if (k == FCLKS + 3) trmt = 1'b0;
         k++;
      end
      $display("test_back_to_back: two frames sent with trmt held");
   endtask

   initial begin
      rst     = 1'b1;
      trmt    = 1'b0;
      tx_data = 8'h00;
      test_reset();
      test_frame(8'hA5);
      test_ignore();
      test_reset_mid();
      test_back_to_back();
      test_frame(8'h07);
      test_frame(8'hFF);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
